// File: rtl/mac_pkg.sv
// Shared definitions for the saturating MAC datapath and the matrix-vector sequencer.
package mac_pkg;

    localparam int DATA_W = 14;
    localparam int ACC_W  = 28;

    localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CLR   = 3'd1,
        S_FEED  = 3'd2,
        S_DRAIN = 3'd3,
        S_WRITE = 3'd4,
        S_DONE  = 3'd5
    } seq_state_e;

endpackage

// File: rtl/mac_mv_sequencer.sv
// Matrix-vector sequencer: streams each row of M together with x through an external
// saturating MAC and writes one saturated dot product per row into the result memory.
module mac_mv_sequencer #(
    parameter int ROWS    = 3,
    parameter int COLS    = 4,
    parameter int DATA_W  = mac_pkg::DATA_W,
    parameter int ACC_W   = mac_pkg::ACC_W,
    parameter int MAC_LAT = 1,
    localparam int MA_W   = (ROWS * COLS > 1) ? $clog2(ROWS * COLS) : 1,
    localparam int XA_W   = (COLS > 1) ? $clog2(COLS) : 1,
    localparam int YA_W   = (ROWS > 1) ? $clog2(ROWS) : 1
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     start,
    output logic                     busy,
    output logic                     done,
    output logic [MA_W-1:0]          m_addr,
    input  logic [DATA_W-1:0]        m_data,
    output logic [XA_W-1:0]          x_addr,
    input  logic [DATA_W-1:0]        x_data,
    output logic [YA_W-1:0]          y_addr,
    output logic [ACC_W-1:0]         y_data,
    output logic                     y_wr_en,
    output logic                     y_sat,
    output logic [DATA_W-1:0]        mac_a,
    output logic [DATA_W-1:0]        mac_b,
    output logic                     mac_valid_in,
    output logic                     mac_clr,
    input  logic [ACC_W-1:0]         mac_f,
    input  logic                     mac_valid_out
);
    import mac_pkg::*;

    localparam int              VC_W      = $clog2(COLS + 1);
    localparam logic [XA_W-1:0] COL_LAST  = XA_W'(COLS - 1);
    localparam logic [YA_W-1:0] ROW_LAST  = YA_W'(ROWS - 1);
    localparam logic [VC_W-1:0] VCNT_LAST = VC_W'(COLS - 1);

    if ((MAC_LAT < 1) || (ROWS < 1) || (COLS < 1)) begin : g_bad_params
        $error("mac_mv_sequencer: ROWS, COLS and MAC_LAT must all be >= 1");
    end

    function automatic logic is_saturated(input logic [ACC_W-1:0] v);
        return (v == {1'b0, {(ACC_W-1){1'b1}}}) || (v == {1'b1, {(ACC_W-1){1'b0}}});
    endfunction

    seq_state_e        state_r, state_nxt;
    logic [YA_W-1:0]   row_r, row_nxt;
    logic [XA_W-1:0]   col_r, col_nxt;
    logic [VC_W-1:0]   vcnt_r, vcnt_nxt;
    logic              cap_s;
    logic              issue_r;
    logic [MA_W-1:0]   m_addr_r;
    logic              busy_r;
    logic              done_r;
    logic              clr_r;
    logic              wr_r;
    logic              sat_r;
    logic [YA_W-1:0]   y_addr_r;
    logic [ACC_W-1:0]  y_data_r;

    // Next-state, row/column/result counters and row-result capture decision
    always_comb begin
        state_nxt = state_r;
        row_nxt   = row_r;
        col_nxt   = col_r;
        vcnt_nxt  = vcnt_r;
        cap_s     = 1'b0;
        case (state_r)
            S_IDLE: begin
                if (start) begin
                    state_nxt = S_CLR;
                    row_nxt   = '0;
                end else begin
                    state_nxt = S_IDLE;
                end
            end
            S_CLR: begin
                col_nxt   = '0;
                vcnt_nxt  = '0;
                state_nxt = S_FEED;
            end
            S_FEED: begin
                if (col_r == COL_LAST) begin
                    state_nxt = S_DRAIN;
                end else begin
                    col_nxt = col_r + XA_W'(1);
                end
            end
            S_DRAIN: begin
                state_nxt = S_DRAIN;
            end
            S_WRITE: begin
                if (row_r == ROW_LAST) begin
                    state_nxt = S_DONE;
                end else begin
                    row_nxt   = row_r + YA_W'(1);
                    state_nxt = S_CLR;
                end
            end
            S_DONE: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
        // Results arriving outside FEED/DRAIN belong to no row and are dropped
        if (((state_r == S_FEED) || (state_r == S_DRAIN)) && mac_valid_out) begin
            if (vcnt_r == VCNT_LAST) begin
                cap_s     = 1'b1;
                vcnt_nxt  = VC_W'(COLS);
                state_nxt = S_WRITE;
            end else begin
                vcnt_nxt = vcnt_r + VC_W'(1);
            end
        end else begin
            cap_s = 1'b0;
        end
    end

    // FSM state and counters
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= S_IDLE;
            row_r   <= '0;
            col_r   <= '0;
            vcnt_r  <= '0;
        end else begin
            state_r <= state_nxt;
            row_r   <= row_nxt;
            col_r   <= col_nxt;
            vcnt_r  <= vcnt_nxt;
        end
    end

    // Registered strobes, M address walk and captured row result
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
            clr_r    <= 1'b0;
            issue_r  <= 1'b0;
            wr_r     <= 1'b0;
            sat_r    <= 1'b0;
            m_addr_r <= '0;
            y_addr_r <= '0;
            y_data_r <= '0;
        end else begin
            busy_r  <= (state_nxt != S_IDLE);
            done_r  <= (state_nxt == S_DONE);
            clr_r   <= (state_nxt == S_CLR);
            issue_r <= (state_r == S_FEED);
            wr_r    <= cap_s;
            sat_r   <= cap_s ? is_saturated(mac_f) : 1'b0;
            // M is walked row-major, so one increment per FEED cycle lands on the next row base
            if ((state_r == S_IDLE) && start) begin
                m_addr_r <= '0;
            end else if (state_r == S_FEED) begin
                m_addr_r <= m_addr_r + MA_W'(1);
            end else begin
                m_addr_r <= m_addr_r;
            end
            if (cap_s) begin
                y_addr_r <= row_r;
                y_data_r <= mac_f;
            end else begin
                y_addr_r <= y_addr_r;
                y_data_r <= y_data_r;
            end
        end
    end

    assign busy         = busy_r;
    assign done         = done_r;
    assign m_addr       = m_addr_r;
    assign x_addr       = col_r;
    assign y_addr       = y_addr_r;
    assign y_data       = y_data_r;
    assign y_wr_en      = wr_r;
    assign y_sat        = sat_r;
    assign mac_a        = m_data;
    assign mac_b        = x_data;
    assign mac_valid_in = issue_r;
    assign mac_clr      = clr_r;

endmodule

// File: tb/tb_mac_mv_sequencer.sv
// Directed bench for mac_mv_sequencer: two instances (2x3 and 2x4) with behavioural
// operand memories and a saturating MAC model.
module tb_mac_mv_sequencer;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // ---------------- instance A: ROWS=2, COLS=3, MAC_LAT=1 (P=7) ----------------
    logic               a_start = 1'b0;
    logic               a_busy, a_done, a_y_wr_en, a_y_sat, a_vi, a_clr;
    logic [2:0]         a_m_addr;
    logic [1:0]         a_x_addr;
    logic [0:0]         a_y_addr;
    logic [27:0]        a_y_data;
    logic [13:0]        a_mac_a, a_mac_b;
    logic [13:0]        a_m_data, a_x_data;
    logic signed [27:0] a_f = '0;
    logic               a_vo = 1'b0;
    logic signed [13:0] a_mem_m [0:7];
    logic signed [13:0] a_mem_x [0:3];

    // ---------------- instance B: ROWS=2, COLS=4, MAC_LAT=1 (P=8) ----------------
    logic               b_start = 1'b0;
    logic               b_busy, b_done, b_y_wr_en, b_y_sat, b_vi, b_clr;
    logic [2:0]         b_m_addr;
    logic [1:0]         b_x_addr;
    logic [0:0]         b_y_addr;
    logic [27:0]        b_y_data;
    logic [13:0]        b_mac_a, b_mac_b;
    logic [13:0]        b_m_data, b_x_data;
    logic signed [27:0] b_f = '0;
    logic               b_vo = 1'b0;
    logic signed [13:0] b_mem_m [0:7];
    logic signed [13:0] b_mem_x [0:3];

    int a_done_cnt = 0;
    int a_wr_cnt = 0;
    int a_vi_cnt = 0;
    int a_ovl_cnt = 0;

    mac_mv_sequencer #(.ROWS(2), .COLS(3), .DATA_W(14), .ACC_W(28), .MAC_LAT(1)) u_dut_a (
        .clk(clk), .reset_n(reset_n), .start(a_start), .busy(a_busy), .done(a_done),
        .m_addr(a_m_addr), .m_data(a_m_data), .x_addr(a_x_addr), .x_data(a_x_data),
        .y_addr(a_y_addr), .y_data(a_y_data), .y_wr_en(a_y_wr_en), .y_sat(a_y_sat),
        .mac_a(a_mac_a), .mac_b(a_mac_b), .mac_valid_in(a_vi), .mac_clr(a_clr),
        .mac_f(a_f), .mac_valid_out(a_vo)
    );

    mac_mv_sequencer #(.ROWS(2), .COLS(4), .DATA_W(14), .ACC_W(28), .MAC_LAT(1)) u_dut_b (
        .clk(clk), .reset_n(reset_n), .start(b_start), .busy(b_busy), .done(b_done),
        .m_addr(b_m_addr), .m_data(b_m_data), .x_addr(b_x_addr), .x_data(b_x_data),
        .y_addr(b_y_addr), .y_data(b_y_data), .y_wr_en(b_y_wr_en), .y_sat(b_y_sat),
        .mac_a(b_mac_a), .mac_b(b_mac_b), .mac_valid_in(b_vi), .mac_clr(b_clr),
        .mac_f(b_f), .mac_valid_out(b_vo)
    );

    function automatic logic signed [27:0] sat_mac(input logic signed [27:0] acc,
                                                   input logic signed [13:0] a,
                                                   input logic signed [13:0] b);
        longint s;
        s = longint'(acc) + longint'(a) * longint'(b);
        if (s > 64'sd134217727) s = 64'sd134217727;
        if (s < -64'sd134217728) s = -64'sd134217728;
        return 28'(s);
    endfunction

    // synchronous-read operand memories and MAC models (MAC_LAT=1, not reset by reset_n)
    always @(posedge clk) begin
        a_m_data <= a_mem_m[a_m_addr];
        a_x_data <= a_mem_x[a_x_addr];
        b_m_data <= b_mem_m[b_m_addr];
        b_x_data <= b_mem_x[b_x_addr];
        if (a_clr) begin
            a_f <= '0; a_vo <= 1'b0;
        end else if (a_vi) begin
            a_f <= sat_mac(a_f, a_mac_a, a_mac_b); a_vo <= 1'b1;
        end else begin
            a_vo <= 1'b0;
        end
        if (b_clr) begin
            b_f <= '0; b_vo <= 1'b0;
        end else if (b_vi) begin
            b_f <= sat_mac(b_f, b_mac_a, b_mac_b); b_vo <= 1'b1;
        end else begin
            b_vo <= 1'b0;
        end
    end

    always @(negedge clk) begin
        if (reset_n) begin
            if (a_done) a_done_cnt <= a_done_cnt + 1;
            if (a_y_wr_en) a_wr_cnt <= a_wr_cnt + 1;
            if (a_vi) a_vi_cnt <= a_vi_cnt + 1;
            if (a_vi && a_clr) a_ovl_cnt <= a_ovl_cnt + 1;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_zero_a(input string pfx);
        check({pfx, "_busy"}, a_busy, 0);
        check({pfx, "_done"}, a_done, 0);
        check({pfx, "_wr"}, a_y_wr_en, 0);
        check({pfx, "_sat"}, a_y_sat, 0);
        check({pfx, "_vi"}, a_vi, 0);
        check({pfx, "_clr"}, a_clr, 0);
        check({pfx, "_maddr"}, a_m_addr, 0);
        check({pfx, "_xaddr"}, a_x_addr, 0);
        check({pfx, "_yaddr"}, a_y_addr, 0);
        check({pfx, "_ydata"}, a_y_data, 0);
    endtask

    // Expected per-cycle behaviour of instance A, cycle 1 = CLR of row 0
    task automatic chk_cycle_a(input int c, input int y0, input int y1);
        int r;
        int off;
        bit run;
        r = (c - 1) / 7;
        off = c - r * 7;
        run = (c <= 14);
        check($sformatf("busy@%0d", c), a_busy, (c <= 15));
        check($sformatf("done@%0d", c), a_done, (c == 15));
        check($sformatf("clr@%0d", c), a_clr, (run && off == 1));
        check($sformatf("vi@%0d", c), a_vi, (run && off >= 3 && off <= 5));
        check($sformatf("wr@%0d", c), a_y_wr_en, (run && off == 7));
        if (run && off >= 2 && off <= 4) begin
            check($sformatf("maddr@%0d", c), a_m_addr, r * 3 + off - 2);
            check($sformatf("xaddr@%0d", c), a_x_addr, off - 2);
        end
        if (run && off == 7) begin
            check($sformatf("yaddr@%0d", c), a_y_addr, r);
            check($sformatf("ydata@%0d", c), $signed(a_y_data), (r == 0) ? y0 : y1);
            check($sformatf("ysat@%0d", c), a_y_sat, 0);
        end
    endtask

    task automatic run_b(input int y0, input int y1, input bit s0, input bit s1, input bit swap_x);
        b_start = 1'b1;
        tick();
        b_start = 1'b0;
        for (int c = 1; c <= 17; c++) begin
            if (swap_x && c == 9) begin
                for (int i = 0; i < 4; i++) b_mem_x[i] = 14'sd1;
            end
            check($sformatf("b_wr@%0d", c), b_y_wr_en, (c == 8 || c == 16));
            check($sformatf("b_done@%0d", c), b_done, (c == 17));
            if (c == 8 || c == 16) begin
                check($sformatf("b_yaddr@%0d", c), b_y_addr, (c == 16));
                check($sformatf("b_ydata@%0d", c), $signed(b_y_data), (c == 8) ? y0 : y1);
                check($sformatf("b_ysat@%0d", c), b_y_sat, (c == 8) ? s0 : s1);
            end
            tick();
        end
    endtask

    initial begin
        int wr_base;
        int done_base;
        int vi_base;
        a_mem_m[0] = 14'sd1;  a_mem_m[1] = 14'sd2; a_mem_m[2] = 14'sd3;
        a_mem_m[3] = -14'sd4; a_mem_m[4] = 14'sd5; a_mem_m[5] = -14'sd6;
        a_mem_m[6] = 14'sd0;  a_mem_m[7] = 14'sd0;
        a_mem_x[0] = 14'sd7;  a_mem_x[1] = 14'sd8; a_mem_x[2] = 14'sd9; a_mem_x[3] = 14'sd0;
        for (int i = 0; i < 8; i++) b_mem_m[i] = 14'sd8191;
        for (int i = 0; i < 4; i++) b_mem_x[i] = 14'sd8191;

        // reset state
        repeat (2) tick();
        chk_zero_a("rst");
        check("rst_b_busy", b_busy, 0);
        reset_n = 1'b1;
        tick();

        // basic run
        a_start = 1'b1;
        tick();
        a_start = 1'b0;
        for (int c = 1; c <= 16; c++) begin
            chk_cycle_a(c, 50, -42);
            tick();
        end

        // start held high for the whole run: one computation only
        wr_base = a_wr_cnt; done_base = a_done_cnt; vi_base = a_vi_cnt;
        a_start = 1'b1;
        tick();
        for (int c = 1; c <= 16; c++) begin
            if (c == 16) a_start = 1'b0;
            chk_cycle_a(c, 50, -42);
            tick();
        end
        repeat (3) tick();
        check("held_done_cnt", a_done_cnt - done_base, 1);
        check("held_wr_cnt", a_wr_cnt - wr_base, 2);
        check("held_vi_cnt", a_vi_cnt - vi_base, 6);
        check("held_idle", a_busy, 0);

        // start in the DONE cycle ignored, start in the following cycle begins a new run
        a_start = 1'b1;
        tick();
        a_start = 1'b0;
        for (int c = 1; c <= 15; c++) begin
            if (c == 15) a_start = 1'b1;
            chk_cycle_a(c, 50, -42);
            tick();
        end
        check("done_start_busy", a_busy, 0);
        check("done_start_clr", a_clr, 0);
        tick();
        a_start = 1'b0;
        for (int c = 1; c <= 16; c++) begin
            chk_cycle_a(c, 50, -42);
            tick();
        end

        // reset during row 1 FEED
        wr_base = a_wr_cnt;
        a_start = 1'b1;
        tick();
        a_start = 1'b0;
        for (int c = 1; c <= 9; c++) begin
            chk_cycle_a(c, 50, -42);
            tick();
        end
        reset_n = 1'b0;
        #1;
        chk_zero_a("midrst");
        tick();
        reset_n = 1'b1;
        repeat (20) tick();
        check("midrst_wr_cnt", a_wr_cnt - wr_base, 1);
        check("midrst_idle", a_busy, 0);
        a_start = 1'b1;
        tick();
        a_start = 1'b0;
        for (int c = 1; c <= 16; c++) begin
            chk_cycle_a(c, 50, -42);
            tick();
        end
        check("no_clr_vi_overlap", a_ovl_cnt, 0);

        // positive saturation on both rows
        run_b(134217727, 134217727, 1'b1, 1'b1, 1'b0);

        // negative saturation, then a small row after the per-row clear
        for (int i = 0; i < 4; i++) b_mem_m[i] = 14'h2000;
        for (int i = 4; i < 8; i++) b_mem_m[i] = 14'sd1;
        run_b(-134217728, 4, 1'b1, 1'b0, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mac_mv_sequencer.md
# mac_mv_sequencer

Controller that sequences the shared saturating MAC (14-bit signed operands, 28-bit saturating accumulator) through a matrix-vector product y = M·x. On `start` it streams each row of M and the vector x from two synchronous read memories into the MAC. It clears the accumulator before every row and writes each row's saturated sum into a result memory. It sits between the operand/result memories and a MAC instantiated alongside it at the accelerator level.

## Interface
- ROWS, 3, rows of M and entries of y (≥1)
- COLS, 4, columns of M and entries of x (≥1)
- DATA_W, 14, operand width (signed)
- ACC_W, 28, accumulator/result width (signed)
- MAC_LAT, 1, cycles from MAC sampling `valid_in` to the matching `valid_out`/`f` (≥1)
- clk  in  1  clock; all state on rising edge
- reset_n  in  1  asynchronous, active-low reset
- start  in  1  begin computation; sampled only in IDLE
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse when the last y entry has been written
- m_addr  out  clog2(ROWS*COLS)  M read address, row-major (row*COLS+col)
- m_data  in  DATA_W  M read data, valid 1 cycle after m_addr
- x_addr  out  clog2(COLS)  x read address
- x_data  in  DATA_W  x read data, valid 1 cycle after x_addr
- y_addr  out  clog2(ROWS)  result write address
- y_data  out  ACC_W  result write data
- y_wr_en  out  1  result write strobe
- y_sat  out  1  high with y_wr_en when y_data equals +2^(ACC_W-1)-1 or -2^(ACC_W-1)
- mac_a, mac_b  out  DATA_W  MAC operands; combinational pass-through of m_data, x_data
- mac_valid_in  out  1  MAC operand strobe
- mac_clr  out  1  MAC active-high synchronous accumulator/pipeline clear
- mac_f  in  ACC_W  MAC saturated accumulator
- mac_valid_out  in  1  MAC result strobe

## Operation
- States: IDLE, CLR, FEED, DRAIN, WRITE, DONE.
- IDLE: start=1 → CLR, row←0. start in any other state is ignored, including the DONE cycle.
- CLR (1 cycle): mac_clr=1. col←0, vcnt←0 → FEED.
- FEED (COLS cycles): m_addr=row*COLS+col, x_addr=col, col++. An internal issue flag is registered, so mac_valid_in=1 exactly one cycle after each address cycle. Last column → DRAIN.
- vcnt counts mac_valid_out in FEED and DRAIN. In the cycle vcnt reaches COLS, mac_f is registered → WRITE.
- WRITE (1 cycle): y_wr_en=1, y_addr=row, y_data=captured f, y_sat per the saturation compare. Then, if row<ROWS-1: row++ → CLR. Otherwise → DONE.
- DONE (1 cycle): done=1 → IDLE.
- Results are never re-saturated: the MAC saturates, and y_data carries mac_f bit-exact.
- mac_valid_out outside FEED/DRAIN is ignored.

## Timing
- Reset (async assert, sync release):
  - state=IDLE, row/col/vcnt=0.
  - busy, done, y_wr_en, y_sat, mac_valid_in, mac_clr=0.
  - all address/data outputs=0.
- Reset mid-operation aborts with no further y writes. The next computation re-clears the MAC in CLR.
- Row period P = COLS+MAC_LAT+3 cycles: CLR 1, FEED COLS, +1 memory latency, +MAC_LAT, WRITE 1.
- Cycle 1 = first cycle after the edge sampling start; CLR occurs in cycle 1.
- Row r: CLR in cycle 1+r*P, WRITE in cycle (r+1)*P.
- done high in cycle ROWS*P+1. busy high in cycles 1..ROWS*P+1.
- mac_clr and mac_valid_in are never high in the same cycle.

## Structure
- Shared package mac_pkg:
  - DATA_W, ACC_W
  - ACC_MAX/ACC_MIN saturation constants
  - state enum type
- The MAC reuses mac_pkg.
- Single module; the MAC stays outside and is wired at the top level. No sub-module needed.

## Test plan
All scenarios use ROWS=2, COLS=3, MAC_LAT=1 (P=7) unless noted.
- Basic: M=[1,2,3;−4,5,−6], x=[7,8,9] → y[0]=50 at cycle 7, y[1]=−42 at cycle 14. y_sat=0 both. done in cycle 15.
- Positive saturation (COLS=4): all M and x entries = 8191 → y_data=134217727, y_sat=1 each row.
- Negative saturation (COLS=4): M=−8192, x=8191 → y_data=−134217728, y_sat=1. Next row M=1, x=1 → y=4, confirming per-row clear.
- Start handling:
  - start held high throughout → exactly one computation, one done.
  - start pulsed in the DONE cycle → ignored.
  - start pulsed the following cycle → a new run begins with CLR.
- Reset mid-run: reset_n low during row 1 FEED → outputs 0 immediately, no write for row 1. A restart then produces correct y[0], y[1].
- Protocol checks:
  - mac_valid_in asserted exactly COLS cycles per row.
  - Each mac_valid_in is one cycle after its address.
  - y_wr_en asserted exactly ROWS times per run.
